pc_fetch_f: RTL
===============

Name: pc_fetch_F

Overview:
- Fetch-stage front end of the 5-stage MIPS pipeline: PC register, next-PC selection and the F/D pipeline register.
- Consumes the D-stage redirect decisions: Branch from the D-stage comparator, plus jump/jump-register indications from D-stage decode.
- Drives the instruction-memory address and presents the fetched instruction/PC to D.
- MIPS branch-delay-slot semantics: no flush; the instruction after a branch/jump always executes.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset (start of text segment).
- NOP_INSTR, 32'h0000_0000, Instr_D value after reset (sll $0,$0,0).

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- Stall  in  1  hazard-unit stall; freeze PC_F and the F/D register
- Branch  in  1  taken beq resolved in D (comparator output)
- Jump  in  1  D instruction is j/jal
- JumpReg  in  1  D instruction is jr/jalr
- RD1_D  in  32  forwarded rs value in D (jr target)
- Instr_F  in  32  instruction read combinationally from IM at PC_F
- PC_F  out  32  current fetch address to IM
- Instr_D  out  32  F/D register: instruction
- PC_D  out  32  F/D register: PC of Instr_D
- PC8_D  out  32  PC_D + 8 (link address for jal/jalr)

Behaviour:
- Reset (synchronous, highest priority, overrides Stall):
  - PC_F <= PC_RESET.
  - Instr_D <= NOP_INSTR.
  - PC_D <= PC_RESET.
  - PC8_D therefore reads PC_RESET+8.
- Targets, computed combinationally from D-stage fields (imm16 = Instr_D[15:0], imm26 = Instr_D[25:0]):
  - br_target = PC_D + 4 + (sign_extend(imm16) << 2).
  - j_target = {PC_D[31:28], imm26, 2'b00}. PC_D is used, not PC_F; the delay slot lies in the same 256 MB region by ISA.
  - jr_target = RD1_D.
- Next PC, selected when not stalled, in priority order:
  - JumpReg -> jr_target
  - else Jump -> j_target
  - else Branch -> br_target
  - else PC_F + 4
  - Decode guarantees these selects are exclusive; the fixed priority makes overlap deterministic.
- Normal cycle (Stall=0, reset=0):
  - PC_F <= NPC.
  - Instr_D <= Instr_F.
  - PC_D <= PC_F.
- Stall cycle (Stall=1, reset=0):
  - PC_F, Instr_D and PC_D all hold.
  - Redirect inputs are ignored. The branch stays in D and re-evaluates once its forwarded operands are valid.
- Latency:
  - A redirect asserted in cycle n (branch in D, delay slot in F) sets PC_F = target in cycle n+1.
  - In the same edge, the delay-slot instruction moves to D.
  - Exactly one delay-slot instruction always passes; no instruction is ever killed.
- Arithmetic: all PC adds are 32-bit modulo 2^32; wrap at 0xFFFF_FFFC -> 0x0000_0000 is silent.
- No alignment checking: jr to an unaligned RD1_D is loaded as-is. IM truncates low bits; exceptions are out of scope.
- Reset mid-stall or mid-redirect: reset wins; pipeline restarts from PC_RESET on the next cycle.
- Outputs are registered or pure functions of registers. Only NPC depends combinationally on Branch/Jump/JumpReg/RD1_D; it never reaches PC_F the same cycle.

Decomposition:
- Shared macros include (the existing one with opcode macros) gains:
  - PC_RESET_ADDR and NOP_INSTR constants, used as parameter defaults.
  - The NPC select encoding (NPC_PC4, NPC_BR, NPC_J, NPC_JR, 2 bits).
- One combinational sub-module, npc: inputs PC_F, PC_D, Instr_D, RD1_D and the three selects; output NPC.
- The top holds the PC register and the F/D register.

Test Plan:
- Reset then 3 free-running cycles, Instr_F constant -> PC_F sequence 0x3000, 0x3004, 0x3008, 0x300C; PC_D lags by one; PC8_D = PC_D+8.
- beq fetched at 0x3004 with imm16=0x0003; Branch=1 while PC_D=0x3004 -> next PC_F=0x3014; PC_D=0x3008 (delay slot delivered).
- Repeat with Branch=0 and with imm16=0xFFFE (negative) -> not-taken gives PC_F=0x300C; taken gives 0x3008+(-8)=0x3000.
- j with imm26=0x0000C10 at PC_D=0x3010 -> PC_F=0x0000_3040; jr with RD1_D=0x0000_3100 and Jump, Branch also high -> PC_F=0x3100 (JumpReg priority).
- Stall=1 for 2 cycles with Branch=1 -> PC_F/Instr_D/PC_D unchanged both cycles. Then Stall=0 with Branch=1 -> redirect taken exactly once.
- reset asserted together with Stall=1 and JumpReg=1 -> PC_F=0x3000, Instr_D=0, PC_D=0x3000 next cycle.

Source files
------------

// File: rtl/pc_fetch_f_pkg.sv
// Shared fetch-stage constants and the next-PC select encoding.
package pc_fetch_f_pkg;

    localparam logic [31:0] PC_RESET_ADDR = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

    typedef enum logic [1:0] {
        NPC_PC4 = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    // Fixed priority keeps simultaneous selects deterministic.
    function automatic npc_sel_e npc_select(input logic branch, input logic jump,
                                            input logic jump_reg);
        if (jump_reg)    return NPC_JR;
        else if (jump)   return NPC_J;
        else if (branch) return NPC_BR;
        else             return NPC_PC4;
    endfunction

endpackage

// File: rtl/pc_fetch_f_npc.sv
// Combinational next-PC selection from D-stage redirect decisions.
module pc_fetch_f_npc
    import pc_fetch_f_pkg::*;
(
    input  logic [31:0] i_pc_f,
    input  logic [31:0] i_pc_d,
    input  logic [25:0] i_imm26,
    input  logic [31:0] i_rd1_d,
    input  logic        i_branch,
    input  logic        i_jump,
    input  logic        i_jump_reg,
    output logic [31:0] o_npc
);

    npc_sel_e    w_sel;
    logic [31:0] w_pc4;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_br_offset;

    assign w_sel       = npc_select(i_branch, i_jump, i_jump_reg);
    assign w_pc4       = i_pc_f + 32'd4;
    assign w_br_offset = {{14{i_imm26[15]}}, i_imm26[15:0], 2'b00};
    assign w_br_target = i_pc_d + 32'd4 + w_br_offset;
    // Region bits come from the jump's own PC; the delay slot shares the region.
    assign w_j_target  = {i_pc_d[31:28], i_imm26, 2'b00};

    always_comb begin
        o_npc = w_pc4;
        unique case (w_sel)
            NPC_JR:  o_npc = i_rd1_d;
            NPC_J:   o_npc = w_j_target;
            NPC_BR:  o_npc = w_br_target;
            default: o_npc = w_pc4;
        endcase
    end

endmodule

// File: rtl/pc_fetch_f.sv
// Fetch stage: PC register, next-PC selection and the F/D pipeline register.
module pc_fetch_f
    import pc_fetch_f_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = pc_fetch_f_pkg::PC_RESET_ADDR,
    parameter logic [31:0] NOP_INSTR = pc_fetch_f_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic [31:0] RD1_D,
    input  logic [31:0] Instr_F,
    output logic [31:0] PC_F,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC8_D
);

    logic [31:0] r_pc_f;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] w_npc;

    pc_fetch_f_npc u_npc (
        .i_pc_f     (r_pc_f),
        .i_pc_d     (r_pc_d),
        .i_imm26    (r_instr_d[25:0]),
        .i_rd1_d    (RD1_D),
        .i_branch   (Branch),
        .i_jump     (Jump),
        .i_jump_reg (JumpReg),
        .o_npc      (w_npc)
    );

    // Stall freezes PC and F/D together so a branch in D re-evaluates later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_f    <= PC_RESET;
            r_instr_d <= NOP_INSTR;
            r_pc_d    <= PC_RESET;
        end else if (!Stall) begin
            r_pc_f    <= w_npc;
            r_instr_d <= Instr_F;
            r_pc_d    <= r_pc_f;
        end
    end

    assign PC_F    = r_pc_f;
    assign Instr_D = r_instr_d;
    assign PC_D    = r_pc_d;
    assign PC8_D   = r_pc_d + 32'd8;

endmodule
